prim_edge_gen: RTL and testbench

Serial edge generator; the transmit counterpart of the edge detector primitive. It converts single-cycle rise/fall request pulses into a registered, glitch-free serial level. The block enforces minimum high and low widths and holds one pending opposite edge. It drives PWM/ramp outputs and loopback paths that are sampled by an edge detector.

---
 rtl/prim_edge_gen_pkg.sv | 25 ++
 rtl/prim_ff.sv | 25 ++
 rtl/prim_edge_gen.sv | 154 +++++++++++++++
 tb/tb_prim_edge_gen.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/prim_edge_gen_pkg.sv
// Shared types and constants for the serial edge generator.
package prim_edge_gen_pkg;

  // Level/hold state of the generated serial line
  typedef enum logic [1:0] {
    LOW_READY  = 2'b00,
    LOW_HOLD   = 2'b01,
    HIGH_READY = 2'b10,
    HIGH_HOLD  = 2'b11
  } edge_gen_state_e;

  // Width of the optional saturating dropped-request counter
  localparam int DropCntW = 16;

  // Level currently driven on the serial line for a given state
  function automatic logic stateLevel(input edge_gen_state_e s);
    return (s == HIGH_READY) || (s == HIGH_HOLD);
  endfunction

  // True while a minimum-width hold is being enforced
  function automatic logic stateIsHold(input edge_gen_state_e s);
    return (s == LOW_HOLD) || (s == HIGH_HOLD);
  endfunction

endpackage

// File: rtl/prim_ff.sv
// Generic register bank with asynchronous active-low reset to a fixed value.
module prim_ff #(
  parameter int unsigned      Width      = 1,
  parameter logic [Width-1:0] ResetValue = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  logic [Width-1:0] r_q;

  // Capture the next value every clock, fall back to the reset value asynchronously
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_q <= ResetValue;
    end else begin
      r_q <= d_i;
    end
  end

  assign q_o = r_q;

endmodule

// File: rtl/prim_edge_gen.sv
// Serial edge generator: turns rise/fall request pulses into a registered,
// glitch-free level with minimum high/low widths and one pending edge.
// Optional macro PRIM_EDGE_GEN_DROP_CNT_EN adds a saturating 16-bit
// dropped-request counter on drop_cnt_o.
module prim_edge_gen
  import prim_edge_gen_pkg::*;
#(
  parameter int unsigned MinHigh    = 4,
  parameter int unsigned MinLow     = 4,
  parameter bit          ResetLevel = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic r_req_i,
  input  logic f_req_i,
  output logic serial_o,
  output logic r_edge_o,
  output logic f_edge_o,
  output logic busy_o,
  output logic drop_o
`ifdef PRIM_EDGE_GEN_DROP_CNT_EN
  ,
  output logic [DropCntW-1:0] drop_cnt_o
`endif
);

  localparam int unsigned MaxHold = (MinHigh > MinLow) ? MinHigh : MinLow;
  localparam int          CntW    = $clog2(MaxHold + 1);
  localparam logic [CntW-1:0] HighLoad = CntW'(MinHigh - 1);
  localparam logic [CntW-1:0] LowLoad  = CntW'(MinLow - 1);
  localparam edge_gen_state_e ResetState = ResetLevel ? HIGH_READY : LOW_READY;

  edge_gen_state_e r_state;
  logic [CntW-1:0] r_holdCnt;
  logic            r_pend;

  edge_gen_state_e w_nextState;
  logic [CntW-1:0] w_nextCnt;
  logic            w_nextPend;
  logic            w_toggle;
  logic            w_drop;

  logic w_level;
  logic w_hold;
  logic w_riseReq;
  logic w_fallReq;
  logic w_bothReq;
  logic w_oppReq;
  logic w_sameReq;
  logic w_pendEff;
  logic [3:0] w_ffD;
  logic [3:0] w_ffQ;

  assign w_level   = stateLevel(r_state);
  assign w_hold    = stateIsHold(r_state);
  assign w_riseReq = en_i & r_req_i;
  assign w_fallReq = en_i & f_req_i;
  assign w_bothReq = w_riseReq & w_fallReq;
  assign w_oppReq  = w_level ? w_fallReq : w_riseReq;
  assign w_sameReq = w_level ? w_riseReq : w_fallReq;
  // A pending edge is only honoured while enabled; disabling discards it
  assign w_pendEff = en_i & r_pend;

  // Next-state decision: accept, store or drop requests and run the hold counter
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_holdCnt;
    w_nextPend  = r_pend;
    w_toggle    = 1'b0;
    w_drop      = 1'b0;
    if (!w_hold) begin
      if (w_bothReq) begin
        w_toggle   = 1'b1;
        w_nextPend = 1'b1;
      end else if (w_oppReq || w_pendEff) begin
        w_toggle   = 1'b1;
        w_nextPend = 1'b0;
      end else if (w_sameReq) begin
        w_drop = 1'b1;
      end
    end else begin
      if (w_bothReq) begin
        w_drop = 1'b1;
      end else if (w_oppReq && !w_pendEff) begin
        w_nextPend = 1'b1;
      end else if (w_oppReq || w_sameReq) begin
        w_drop = 1'b1;
      end
      if (r_holdCnt == '0) begin
        if (w_pendEff || (w_oppReq && !w_bothReq)) begin
          w_toggle   = 1'b1;
          w_nextPend = 1'b0;
        end else begin
          w_nextState = w_level ? HIGH_READY : LOW_READY;
        end
      end else begin
        w_nextCnt = r_holdCnt - 1'b1;
      end
    end
    if (w_toggle) begin
      w_nextState = w_level ? LOW_HOLD : HIGH_HOLD;
      w_nextCnt   = w_level ? LowLoad : HighLoad;
    end
    if (!en_i) begin
      w_nextPend = 1'b0;
    end
  end

  // FSM, hold counter and pending-edge register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state   <= ResetState;
      r_holdCnt <= '0;
      r_pend    <= 1'b0;
    end else begin
      r_state   <= w_nextState;
      r_holdCnt <= w_nextCnt;
      r_pend    <= w_nextPend;
    end
  end

  // Serial level, edge pulses and drop pulse share one register stage so they stay aligned
  assign w_ffD = {w_level ^ w_toggle, w_toggle & ~w_level, w_toggle & w_level, w_drop};

  prim_ff #(
    .Width      (4),
    .ResetValue ({ResetLevel, 3'b000})
  ) u_outFf (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .d_i    (w_ffD),
    .q_o    (w_ffQ)
  );

  assign {serial_o, r_edge_o, f_edge_o, drop_o} = w_ffQ;
  assign busy_o = w_hold | r_pend;

`ifdef PRIM_EDGE_GEN_DROP_CNT_EN
  logic [DropCntW-1:0] r_dropCnt;

  // Count discarded requests in step with drop_o, sticking at all-ones
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_dropCnt <= '0;
    end else if (w_drop && (r_dropCnt != '1)) begin
      r_dropCnt <= r_dropCnt + 1'b1;
    end
  end

  assign drop_cnt_o = r_dropCnt;
`endif

endmodule

// File: tb/tb_prim_edge_gen.sv
// Self-checking bench for prim_edge_gen (MinHigh=MinLow=4, ResetLevel=0).
module tb_prim_edge_gen;

  localparam int MinHigh = 4;
  localparam int MinLow  = 4;

  // Expected-output field encoding {serial, r_edge, f_edge, busy, drop}
  localparam logic [4:0] S  = 5'b10000;
  localparam logic [4:0] RE = 5'b01000;
  localparam logic [4:0] FE = 5'b00100;
  localparam logic [4:0] B  = 5'b00010;
  localparam logic [4:0] D  = 5'b00001;

  logic clk_i = 1'b0;
  logic rst_ni;
  logic en_i;
  logic r_req_i;
  logic f_req_i;
  logic serial_o;
  logic r_edge_o;
  logic f_edge_o;
  logic busy_o;
  logic drop_o;
`ifdef PRIM_EDGE_GEN_DROP_CNT_EN
  logic [15:0] drop_cnt_o;
`endif

  typedef struct packed {
    logic       en;
    logic       r;
    logic       f;
    logic [4:0] exp;
  } vec_t;

  vec_t       vecs[$];
  logic [4:0] expQ[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         expDrops   = 0;

  // Free-running clock
  always #5 clk_i = ~clk_i;

  prim_edge_gen #(
    .MinHigh    (MinHigh),
    .MinLow     (MinLow),
    .ResetLevel (1'b0)
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .en_i     (en_i),
    .r_req_i  (r_req_i),
    .f_req_i  (f_req_i),
    .serial_o (serial_o),
    .r_edge_o (r_edge_o),
    .f_edge_o (f_edge_o),
    .busy_o   (busy_o),
    .drop_o   (drop_o)
`ifdef PRIM_EDGE_GEN_DROP_CNT_EN
    ,
    .drop_cnt_o (drop_cnt_o)
`endif
  );

  task automatic addVec(input logic en, input logic r, input logic f, input logic [4:0] e);
    vec_t v;
    v.en  = en;
    v.r   = r;
    v.f   = f;
    v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic addIdles(input int n, input logic [4:0] e);
    for (int k = 0; k < n; k++) addVec(1'b1, 1'b0, 1'b0, e);
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk_i);
    en_i    = v.en;
    r_req_i = v.r;
    f_req_i = v.f;
    expQ.push_back(v.exp);
  endtask

  task automatic checkOutput(input string name);
    logic [4:0] got;
    logic [4:0] exp;
    @(posedge clk_i);
    #1;
    got = {serial_o, r_edge_o, f_edge_o, busy_o, drop_o};
    compared++;
    if (expQ.size() == 0) begin
      mismatched++;
      $display("[TB] FAIL %s: scoreboard empty, got %b", name, got);
    end else begin
      exp = expQ.pop_front();
      if (got !== exp) begin
        mismatched++;
        $display("[TB] FAIL %s: s/re/fe/busy/drop got %b required %b", name, got, exp);
      end
    end
  endtask

  task automatic checkValue(input string name, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin
    logic prevS;
    logic curS;
    int   runLen;
    int   detRise;
    int   detFall;
    int   pulseRise;
    int   pulseFall;

    rst_ni  = 1'b0;
    en_i    = 1'b0;
    r_req_i = 1'b0;
    f_req_i = 1'b0;
    #12;
    checkValue("reset_outputs", 32'({serial_o, r_edge_o, f_edge_o, busy_o, drop_o}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Basic rise, hold, fall, hold
    addVec(1, 0, 0, 5'b0);
    addVec(1, 1, 0, S | RE | B);
    addIdles(3, S | B);
    addIdles(1, S);
    addVec(1, 0, 1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);
    // Fall while already low is dropped
    addVec(1, 0, 1, D);
    addIdles(1, 5'b0);
    // Fall one cycle after rise becomes pending: high exactly MinHigh cycles
    addVec(1, 1, 0, S | RE | B);
    addVec(1, 0, 1, S | B);
    addIdles(2, S | B);
    addIdles(1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);
    // Simultaneous requests in LOW_READY give a full min-width pulse
    addVec(1, 1, 1, S | RE | B);
    addIdles(3, S | B);
    addIdles(1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);
    // Rise, fall, rise: third request dropped
    addVec(1, 1, 0, S | RE | B);
    addVec(1, 0, 1, S | B);
    addVec(1, 1, 0, S | B | D);
    addIdles(1, S | B);
    addIdles(1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);
    // Rise, fall, fall: pending full so second fall dropped
    addVec(1, 1, 0, S | RE | B);
    addVec(1, 0, 1, S | B);
    addVec(1, 0, 1, S | B | D);
    addIdles(1, S | B);
    addIdles(1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);
    // Both requests during hold: one drop, no pending
    addVec(1, 1, 0, S | RE | B);
    addVec(1, 1, 1, S | B | D);
    addIdles(2, S | B);
    addIdles(1, S);
    // Rise while high and ready is dropped
    addVec(1, 1, 0, S | D);
    addIdles(1, S);
    addVec(1, 0, 1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);
    // Disable while fall pending: no fall, busy clears after hold
    addVec(1, 1, 0, S | RE | B);
    addVec(1, 0, 1, S | B);
    addVec(0, 0, 0, S | B);
    addVec(0, 0, 0, S | B);
    addVec(0, 0, 0, S);
    addVec(0, 0, 1, S);
    addVec(0, 1, 1, S);
    addIdles(1, S);
    addVec(1, 0, 1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);
    // Opposite request exactly at hold expiry toggles with exact width
    addVec(1, 1, 0, S | RE | B);
    addIdles(3, S | B);
    addVec(1, 0, 1, FE | B);
    addIdles(3, B);
    addIdles(1, 5'b0);

    foreach (vecs[i]) if (vecs[i].exp[0]) expDrops++;
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("vec%0d", i));
    end
`ifdef PRIM_EDGE_GEN_DROP_CNT_EN
    checkValue("drop_cnt", 32'(drop_cnt_o), 32'(expDrops));
`endif

    // Reset in the middle of a high hold returns to low at once
    applyStimulus(vec_t'{1'b1, 1'b1, 1'b0, S | RE | B});
    checkOutput("pre_reset_rise");
    @(negedge clk_i);
    en_i    = 1'b1;
    r_req_i = 1'b0;
    f_req_i = 1'b0;
    #1 rst_ni = 1'b0;
    #1;
    checkValue("reset_mid_hold", 32'({serial_o, r_edge_o, f_edge_o, busy_o, drop_o}), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    applyStimulus(vec_t'{1'b1, 1'b0, 1'b0, 5'b0});
    checkOutput("post_reset_idle");

    // Random requests with the serial line looped into an edge detector
    prevS     = serial_o;
    runLen    = MinLow;
    detRise   = 0;
    detFall   = 0;
    pulseRise = 0;
    pulseFall = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      en_i    = ($urandom_range(0, 9) != 0);
      r_req_i = ($urandom_range(0, 3) == 0);
      f_req_i = ($urandom_range(0, 3) == 0);
      @(posedge clk_i);
      #1;
      curS = serial_o;
      if (r_edge_o) pulseRise++;
      if (f_edge_o) pulseFall++;
      if (curS && !prevS) detRise++;
      if (!curS && prevS) detFall++;
      if ({r_edge_o, f_edge_o} !== {curS & ~prevS, ~curS & prevS}) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL edge_align cyc%0d: re/fe got %b%b required %b%b", c,
                 r_edge_o, f_edge_o, curS & ~prevS, ~curS & prevS);
      end
      if (curS == prevS) begin
        runLen++;
      end else begin
        checkValue($sformatf("run_width cyc%0d", c), 32'(runLen >= (prevS ? MinHigh : MinLow)), 32'd1);
        runLen = 1;
      end
      prevS = curS;
    end
    checkValue("loop_rise_count", 32'(pulseRise), 32'(detRise));
    checkValue("loop_fall_count", 32'(pulseFall), 32'(detFall));
    checkValue("loop_activity", 32'(detRise > 10), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
